// File: rtl/remote_load_wb.sv
`default_nettype none
// ============================================================================
// remote_load_wb : remote load response buffer, load_info decode, scoreboards
// Optional feature macro: REMOTE_LOAD_WB_BYPASS_EN (same-cycle empty bypass)
// Revision: 1.0
// ============================================================================

package remote_load_wb_pkg;
  typedef struct packed {
    logic       float_wb;
    logic       icache_fetch;
    logic       is_unsigned_op;
    logic       is_byte_op;
    logic       is_hex_op;
    logic [1:0] part_sel;
  } bsg_manycore_load_info_s;
endpackage

module remote_load_wb
  import remote_load_wb_pkg::*;
#(
  parameter int data_width_p      = 32,
  parameter int reg_addr_width_p  = 5,
  parameter int fifo_els_p        = 2,
  parameter int max_out_credits_p = 32,
  localparam int credit_width_lp  = $clog2(max_out_credits_p + 1)
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        issue_v_i,
  input  logic                        issue_load_i,
  input  logic                        issue_float_i,
  input  logic [reg_addr_width_p-1:0] issue_reg_id_i,
  input  logic                        resp_v_i,
  input  logic [data_width_p-1:0]     resp_data_i,
  input  bsg_manycore_load_info_s     resp_load_info_i,
  input  logic [reg_addr_width_p-1:0] resp_reg_id_i,
  output logic                        resp_ready_o,
  output logic                        int_wb_v_o,
  output logic [reg_addr_width_p-1:0] int_wb_reg_o,
  output logic [data_width_p-1:0]     int_wb_data_o,
  input  logic                        int_wb_yumi_i,
  output logic                        float_wb_v_o,
  output logic [reg_addr_width_p-1:0] float_wb_reg_o,
  output logic [data_width_p-1:0]     float_wb_data_o,
  input  logic                        float_wb_yumi_i,
  output logic                        icache_v_o,
  output logic [data_width_p-1:0]     icache_data_o,
  input  logic                        icache_yumi_i,
  output logic [credit_width_lp-1:0]  out_credits_o,
  output logic                        credit_avail_o,
  output logic [31:0]                 int_pending_o,
  output logic [31:0]                 float_pending_o
);

  localparam int ptr_width_lp = (fifo_els_p > 1) ? $clog2(fifo_els_p) : 1;
  localparam int cnt_width_lp = $clog2(fifo_els_p + 1);
  localparam logic [ptr_width_lp-1:0]    last_ptr_lp    = ptr_width_lp'(fifo_els_p - 1);
  localparam logic [cnt_width_lp-1:0]    full_cnt_lp    = cnt_width_lp'(fifo_els_p);
  localparam logic [credit_width_lp-1:0] max_credits_lp = credit_width_lp'(max_out_credits_p);

  typedef struct packed {
    logic [data_width_p-1:0]     data;
    bsg_manycore_load_info_s     info;
    logic [reg_addr_width_p-1:0] reg_id;
  } entry_s;

  entry_s [fifo_els_p-1:0]      mem_q, mem_d;
  logic [ptr_width_lp-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [cnt_width_lp-1:0]      count_q, count_d;
  logic [credit_width_lp-1:0]   credits_q, credits_d;
  logic [31:0]                  int_pending_q, int_pending_d;
  logic [31:0]                  float_pending_q, float_pending_d;

  entry_s                       resp_entry, head;
  logic                         fifo_empty, bypass, head_v;
  logic                         route_icache, route_float, route_int, int_x0;
  logic                         retire, enq, deq;
  logic [7:0]                   byte_sel;
  logic [15:0]                  half_sel;
  logic [data_width_p-1:0]      ext_data;
  logic [31:0]                  int_set, int_clr, float_set, float_clr;

  function automatic logic [ptr_width_lp-1:0] ptr_inc(input logic [ptr_width_lp-1:0] p);
    return (p == last_ptr_lp) ? '0 : p + 1'b1;
  endfunction

  // Head selection and exclusive routing
  always_comb begin
    resp_entry = '{data: resp_data_i, info: resp_load_info_i, reg_id: resp_reg_id_i};
    fifo_empty = (count_q == '0);
`ifdef REMOTE_LOAD_WB_BYPASS_EN
    bypass     = fifo_empty & resp_v_i;
`else
    bypass     = 1'b0;
`endif
    head         = bypass ? resp_entry : mem_q[rd_ptr_q];
    head_v       = ~fifo_empty | bypass;
    route_icache = head.info.icache_fetch;
    route_float  = ~head.info.icache_fetch & head.info.float_wb;
    route_int    = ~head.info.icache_fetch & ~head.info.float_wb;
    int_x0       = route_int & (head.reg_id == '0);

    case (head.info.part_sel)
      2'd0:    byte_sel = head.data[7:0];
      2'd1:    byte_sel = head.data[15:8];
      2'd2:    byte_sel = head.data[23:16];
      default: byte_sel = head.data[31:24];
    endcase
    half_sel = head.info.part_sel[1] ? head.data[31:16] : head.data[15:0];

    if (head.info.is_byte_op)
      ext_data = {{24{~head.info.is_unsigned_op & byte_sel[7]}}, byte_sel};
    else if (head.info.is_hex_op)
      ext_data = {{16{~head.info.is_unsigned_op & half_sel[15]}}, half_sel};
    else
      ext_data = head.data;

    // Data and register outputs read as zero whenever their valid is low.
    int_wb_v_o      = head_v & route_int & ~int_x0;
    int_wb_reg_o    = int_wb_v_o ? head.reg_id : '0;
    int_wb_data_o   = int_wb_v_o ? ext_data : '0;
    float_wb_v_o    = head_v & route_float;
    float_wb_reg_o  = float_wb_v_o ? head.reg_id : '0;
    float_wb_data_o = float_wb_v_o ? head.data : '0;
    icache_v_o      = head_v & route_icache;
    icache_data_o   = icache_v_o ? head.data : '0;

    retire = (int_wb_v_o & int_wb_yumi_i) | (float_wb_v_o & float_wb_yumi_i)
           | (icache_v_o & icache_yumi_i) | (head_v & int_x0);
    resp_ready_o = (count_q != full_cnt_lp);
    enq          = resp_v_i & resp_ready_o & ~(bypass & retire);
    deq          = retire & ~bypass;
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (enq) begin
      mem_d[wr_ptr_q] = resp_entry;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (deq) rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({enq, deq})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Credits and pending-load scoreboards; a new set beats a same-cycle clear
  always_comb begin
    credits_d = credits_q;
    if (issue_v_i & ~retire & (credits_q != max_credits_lp))
      credits_d = credits_q + 1'b1;
    else if (retire & ~issue_v_i & (credits_q != '0))
      credits_d = credits_q - 1'b1;

    int_set   = '0;
    float_set = '0;
    int_clr   = '0;
    float_clr = '0;
    if (issue_v_i & issue_load_i) begin
      if (issue_float_i)
        float_set[issue_reg_id_i] = 1'b1;
      else if (issue_reg_id_i != '0)
        int_set[issue_reg_id_i] = 1'b1;
    end
    if (retire & route_float) float_clr[head.reg_id] = 1'b1;
    if (retire & route_int)   int_clr[head.reg_id]   = 1'b1;
    int_pending_d   = (int_pending_q & ~int_clr) | int_set;
    float_pending_d = (float_pending_q & ~float_clr) | float_set;

    out_credits_o   = credits_q;
    credit_avail_o  = (credits_q != max_credits_lp);
    int_pending_o   = int_pending_q;
    float_pending_o = float_pending_q;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_ptr_q        <= '0;
      wr_ptr_q        <= '0;
      count_q         <= '0;
      credits_q       <= '0;
      int_pending_q   <= '0;
      float_pending_q <= '0;
    end else begin
      rd_ptr_q        <= rd_ptr_d;
      wr_ptr_q        <= wr_ptr_d;
      count_q         <= count_d;
      credits_q       <= credits_d;
      int_pending_q   <= int_pending_d;
      float_pending_q <= float_pending_d;
    end
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(issue_v_i && !retire && credits_q == max_credits_lp))
        else $error("remote_load_wb: issue with outstanding credits at maximum");
      assert (!(retire && !issue_v_i && credits_q == '0))
        else $error("remote_load_wb: retire with no outstanding credits");
      assert (!(int_wb_yumi_i && !int_wb_v_o))
        else $error("remote_load_wb: int_wb_yumi_i without int_wb_v_o");
      assert (!(float_wb_yumi_i && !float_wb_v_o))
        else $error("remote_load_wb: float_wb_yumi_i without float_wb_v_o");
      assert (!(icache_yumi_i && !icache_v_o))
        else $error("remote_load_wb: icache_yumi_i without icache_v_o");
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_remote_load_wb.sv
`timescale 1ns/1ps
`default_nettype none
// Directed-vector bench for remote_load_wb (default build, bypass disabled).
module tb_remote_load_wb;
  import remote_load_wb_pkg::*;

  logic                    clk_i = 1'b0;
  logic                    reset_i;
  logic                    issue_v_i, issue_load_i, issue_float_i;
  logic [4:0]              issue_reg_id_i;
  logic                    resp_v_i;
  logic [31:0]             resp_data_i;
  bsg_manycore_load_info_s resp_load_info_i;
  logic [4:0]              resp_reg_id_i;
  logic                    resp_ready_o;
  logic                    int_wb_v_o, float_wb_v_o, icache_v_o;
  logic [4:0]              int_wb_reg_o, float_wb_reg_o;
  logic [31:0]             int_wb_data_o, float_wb_data_o, icache_data_o;
  logic                    int_wb_yumi_i, float_wb_yumi_i, icache_yumi_i;
  logic [5:0]              out_credits_o;
  logic                    credit_avail_o;
  logic [31:0]             int_pending_o, float_pending_o;
  logic [2:0]              en;  // {int, float, icache} consumer enables

  assign int_wb_yumi_i   = en[2] & int_wb_v_o;
  assign float_wb_yumi_i = en[1] & float_wb_v_o;
  assign icache_yumi_i   = en[0] & icache_v_o;

  remote_load_wb dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .issue_v_i(issue_v_i), .issue_load_i(issue_load_i), .issue_float_i(issue_float_i),
    .issue_reg_id_i(issue_reg_id_i),
    .resp_v_i(resp_v_i), .resp_data_i(resp_data_i), .resp_load_info_i(resp_load_info_i),
    .resp_reg_id_i(resp_reg_id_i), .resp_ready_o(resp_ready_o),
    .int_wb_v_o(int_wb_v_o), .int_wb_reg_o(int_wb_reg_o), .int_wb_data_o(int_wb_data_o),
    .int_wb_yumi_i(int_wb_yumi_i),
    .float_wb_v_o(float_wb_v_o), .float_wb_reg_o(float_wb_reg_o),
    .float_wb_data_o(float_wb_data_o), .float_wb_yumi_i(float_wb_yumi_i),
    .icache_v_o(icache_v_o), .icache_data_o(icache_data_o), .icache_yumi_i(icache_yumi_i),
    .out_credits_o(out_credits_o), .credit_avail_o(credit_avail_o),
    .int_pending_o(int_pending_o), .float_pending_o(float_pending_o)
  );

  always #5 clk_i = ~clk_i;

  // load_info encodings: {float_wb, icache_fetch, unsigned, byte, hex, part_sel[1:0]}
  localparam logic [31:0] LW      = 32'h00;
  localparam logic [31:0] LB_PS2  = 32'h0A;
  localparam logic [31:0] LHU_PS2 = 32'h16;
  localparam logic [31:0] LH_PS0  = 32'h04;
  localparam logic [31:0] FLW     = 32'h40;
  localparam logic [31:0] ICF     = 32'h20;

  typedef struct {
    logic [31:0] iv, il, ifl, ir, rv, rd, ri, rr, en;
    logic [31:0] e_rdy, e_iv, e_ir, e_id, e_fv, e_fr, e_fd, e_cv, e_cd, e_cr, e_ip, e_fp;
  } vec_t;

  localparam int NV = 29;
  vec_t tbl [NV];
  int n_applied = 0;
  int n_fail    = 0;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_applied++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got 0x%08h expected 0x%08h", name, idx, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    issue_v_i = 0; issue_load_i = 0; issue_float_i = 0; issue_reg_id_i = '0;
    resp_v_i = 0; resp_data_i = '0; resp_load_info_i = '0; resp_reg_id_i = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //        iv il fl ir  rv rd            ri       rr en | rdy iv ir id            fv fr fd            cv cd            cr ip      fp
    tbl[0]  = '{1, 1, 0, 5,  0, 0,            LW,      0, 0,  1,  0, 0, 0,            0, 0, 0,            0, 0,            0, 0,      0};
    tbl[1]  = '{0, 0, 0, 0,  1, 32'h80FF7F01, LB_PS2,  5, 4,  1,  0, 0, 0,            0, 0, 0,            0, 0,            1, 32'h20, 0};
    tbl[2]  = '{0, 0, 0, 0,  0, 0,            LW,      0, 4,  1,  1, 5, 32'hFFFFFFFF, 0, 0, 0,            0, 0,            1, 32'h20, 0};
    tbl[3]  = '{0, 0, 0, 0,  0, 0,            LW,      0, 0,  1,  0, 0, 0,            0, 0, 0,            0, 0,            0, 0,      0};
    tbl[4]  = '{1, 1, 0, 7,  0, 0,            LW,      0, 0,  1,  0, 0, 0,            0, 0, 0,            0, 0,            0, 0,      0};
    tbl[5]  = '{1, 1, 0, 7,  1, 32'h8001ABCD, LHU_PS2, 7, 0,  1,  0, 0, 0,            0, 0, 0,            0, 0,            1, 32'h80, 0};
    tbl[6]  = '{0, 0, 0, 0,  1, 32'h8001ABCD, LH_PS0,  7, 0,  1,  1, 7, 32'h00008001, 0, 0, 0,            0, 0,            2, 32'h80, 0};
    tbl[7]  = '{0, 0, 0, 0,  0, 0,            LW,      0, 4,  0,  1, 7, 32'h00008001, 0, 0, 0,            0, 0,            2, 32'h80, 0};
    tbl[8]  = '{0, 0, 0, 0,  0, 0,            LW,      0, 4,  1,  1, 7, 32'hFFFFABCD, 0, 0, 0,            0, 0,            1, 0,      0};
    tbl[9]  = '{0, 0, 0, 0,  0, 0,            LW,      0, 0,  1,  0, 0, 0,            0, 0, 0,            0, 0,            0, 0,      0};
    tbl[10] = '{1, 1, 1, 3,  0, 0,            LW,      0, 0,  1,  0, 0, 0,            0, 0, 0,            0, 0,            0, 0,      0};
    tbl[11] = '{1, 0, 0, 0,  1, 32'h00500093, ICF,     0, 0,  1,  0, 0, 0,            0, 0, 0,            0, 0,            1, 0,      8};
    tbl[12] = '{0, 0, 0, 0,  1, 32'h3F800000, FLW,     3, 0,  1,  0, 0, 0,            0, 0, 0,            1, 32'h00500093, 2, 0,      8};
    tbl[13] = '{0, 0, 0, 0,  0, 0,            LW,      0, 0,  0,  0, 0, 0,            0, 0, 0,            1, 32'h00500093, 2, 0,      8};
    tbl[14] = '{0, 0, 0, 0,  0, 0,            LW,      0, 0,  0,  0, 0, 0,            0, 0, 0,            1, 32'h00500093, 2, 0,      8};
    tbl[15] = '{0, 0, 0, 0,  0, 0,            LW,      0, 7,  0,  0, 0, 0,            0, 0, 0,            1, 32'h00500093, 2, 0,      8};
    tbl[16] = '{0, 0, 0, 0,  0, 0,            LW,      0, 7,  1,  0, 0, 0,            1, 3, 32'h3F800000, 0, 0,            1, 0,      8};
    tbl[17] = '{0, 0, 0, 0,  0, 0,            LW,      0, 7,  1,  0, 0, 0,            0, 0, 0,            0, 0,            0, 0,      0};
    tbl[18] = '{1, 1, 0, 0,  0, 0,            LW,      0, 0,  1,  0, 0, 0,            0, 0, 0,            0, 0,            0, 0,      0};
    tbl[19] = '{0, 0, 0, 0,  1, 32'h12345678, LW,      0, 4,  1,  0, 0, 0,            0, 0, 0,            0, 0,            1, 0,      0};
    tbl[20] = '{0, 0, 0, 0,  0, 0,            LW,      0, 4,  1,  0, 0, 0,            0, 0, 0,            0, 0,            1, 0,      0};
    tbl[21] = '{0, 0, 0, 0,  0, 0,            LW,      0, 4,  1,  0, 0, 0,            0, 0, 0,            0, 0,            0, 0,      0};
    tbl[22] = '{1, 1, 0, 9,  0, 0,            LW,      0, 0,  1,  0, 0, 0,            0, 0, 0,            0, 0,            0, 0,      0};
    tbl[23] = '{0, 0, 0, 0,  1, 32'hDEADBEEF, LW,      9, 4,  1,  0, 0, 0,            0, 0, 0,            0, 0,            1, 32'h200, 0};
    tbl[24] = '{1, 1, 0, 9,  0, 0,            LW,      0, 4,  1,  1, 9, 32'hDEADBEEF, 0, 0, 0,            0, 0,            1, 32'h200, 0};
    tbl[25] = '{0, 0, 0, 0,  0, 0,            LW,      0, 4,  1,  0, 0, 0,            0, 0, 0,            0, 0,            1, 32'h200, 0};
    tbl[26] = '{0, 0, 0, 0,  1, 32'h00000042, LW,      9, 4,  1,  0, 0, 0,            0, 0, 0,            0, 0,            1, 32'h200, 0};
    tbl[27] = '{0, 0, 0, 0,  0, 0,            LW,      0, 4,  1,  1, 9, 32'h00000042, 0, 0, 0,            0, 0,            1, 32'h200, 0};
    tbl[28] = '{0, 0, 0, 0,  0, 0,            LW,      0, 4,  1,  0, 0, 0,            0, 0, 0,            0, 0,            0, 0,      0};

    reset_i = 1'b1;
    en      = 3'b000;
    clear_inputs();
    repeat (3) @(posedge clk_i);
    #1 reset_i = 1'b0;

    for (int i = 0; i < NV; i++) begin
      issue_v_i        = tbl[i].iv[0];
      issue_load_i     = tbl[i].il[0];
      issue_float_i    = tbl[i].ifl[0];
      issue_reg_id_i   = tbl[i].ir[4:0];
      resp_v_i         = tbl[i].rv[0];
      resp_data_i      = tbl[i].rd;
      resp_load_info_i = tbl[i].ri[6:0];
      resp_reg_id_i    = tbl[i].rr[4:0];
      en               = tbl[i].en[2:0];
      @(negedge clk_i);
      chk("resp_ready",   i, 32'(resp_ready_o),    tbl[i].e_rdy);
      chk("int_wb_v",     i, 32'(int_wb_v_o),      tbl[i].e_iv);
      chk("int_wb_reg",   i, 32'(int_wb_reg_o),    tbl[i].e_ir);
      chk("int_wb_data",  i, int_wb_data_o,        tbl[i].e_id);
      chk("float_wb_v",   i, 32'(float_wb_v_o),    tbl[i].e_fv);
      chk("float_wb_reg", i, 32'(float_wb_reg_o),  tbl[i].e_fr);
      chk("float_wb_data",i, float_wb_data_o,      tbl[i].e_fd);
      chk("icache_v",     i, 32'(icache_v_o),      tbl[i].e_cv);
      chk("icache_data",  i, icache_data_o,        tbl[i].e_cd);
      chk("out_credits",  i, 32'(out_credits_o),   tbl[i].e_cr);
      chk("int_pending",  i, int_pending_o,        tbl[i].e_ip);
      chk("float_pending",i, float_pending_o,      tbl[i].e_fp);
      next_cycle();
    end

    // Fill the credit counter to its maximum with non-load requests.
    clear_inputs();
    en = 3'b000;
    for (int i = 0; i < 32; i++) begin
      issue_v_i = 1'b1;
      next_cycle();
    end
    issue_v_i        = 1'b0;
    resp_v_i         = 1'b1;
    resp_data_i      = 32'h00000013;
    resp_load_info_i = ICF[6:0];
    en               = 3'b001;
    @(negedge clk_i);
    chk("credits_at_max", 0, 32'(out_credits_o), 32);
    chk("avail_at_max",   0, 32'(credit_avail_o), 0);
    next_cycle();
    resp_v_i = 1'b0;
    @(negedge clk_i);
    chk("fill_icache_v",  0, 32'(icache_v_o), 1);
    chk("fill_icache_d",  0, icache_data_o, 32'h00000013);
    next_cycle();
    @(negedge clk_i);
    chk("credits_after_retire", 0, 32'(out_credits_o), 31);
    chk("avail_after_retire",   0, 32'(credit_avail_o), 1);

    // Buffer two unconsumed responses, then reset over them.
    next_cycle();
    en               = 3'b000;
    issue_v_i        = 1'b1;
    issue_load_i     = 1'b1;
    issue_reg_id_i   = 5'd4;
    resp_v_i         = 1'b1;
    resp_data_i      = 32'h00000055;
    resp_load_info_i = LW[6:0];
    resp_reg_id_i    = 5'd4;
    next_cycle();
    clear_inputs();
    resp_v_i         = 1'b1;
    resp_data_i      = 32'h00000066;
    resp_load_info_i = FLW[6:0];
    resp_reg_id_i    = 5'd1;
    next_cycle();
    resp_v_i = 1'b0;
    @(negedge clk_i);
    chk("prereset_ready",   0, 32'(resp_ready_o), 0);
    chk("prereset_int_v",   0, 32'(int_wb_v_o), 1);
    chk("prereset_int_d",   0, int_wb_data_o, 32'h00000055);
    chk("prereset_credits", 0, 32'(out_credits_o), 32);
    chk("prereset_pend",    0, int_pending_o, 32'h10);
    next_cycle();
    reset_i = 1'b1;
    next_cycle();
    reset_i = 1'b0;
    @(negedge clk_i);
    chk("rst_ready",     0, 32'(resp_ready_o), 1);
    chk("rst_int_v",     0, 32'(int_wb_v_o), 0);
    chk("rst_int_reg",   0, 32'(int_wb_reg_o), 0);
    chk("rst_int_data",  0, int_wb_data_o, 0);
    chk("rst_float_v",   0, 32'(float_wb_v_o), 0);
    chk("rst_float_d",   0, float_wb_data_o, 0);
    chk("rst_icache_v",  0, 32'(icache_v_o), 0);
    chk("rst_icache_d",  0, icache_data_o, 0);
    chk("rst_credits",   0, 32'(out_credits_o), 0);
    chk("rst_avail",     0, 32'(credit_avail_o), 1);
    chk("rst_int_pend",  0, int_pending_o, 0);
    chk("rst_fp_pend",   0, float_pending_o, 0);
    en = 3'b111;
    next_cycle();
    @(negedge clk_i);
    chk("post_rst_int_v",   0, 32'(int_wb_v_o), 0);
    chk("post_rst_float_v", 0, 32'(float_wb_v_o), 0);
    chk("post_rst_credits", 0, 32'(out_credits_o), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/remote_load_wb.md
Name: remote_load_wb

Overview:
- Return-path counterpart of the load/store unit's remote request generator.
- Accepts remote load responses from the network RX endpoint and buffers them in a small FIFO.
- Decodes each response's echoed load_info (part_sel, byte/hex, unsigned, float_wb, icache_fetch) into an integer-RF write, FP-RF write or icache fill.
- Tracks outstanding remote requests and per-register pending loads for the hazard logic.

Parameters:
- data_width_p, 32, response/RF data width (only 32 supported).
- reg_addr_width_p, 5, register index width.
- fifo_els_p, 2, response buffer depth (>=2).
- max_out_credits_p, 32, maximum outstanding remote requests.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- issue_v_i  in  1  remote request accepted by network TX this cycle
- issue_load_i  in  1  issued request returns data to a register (load, non-icache)
- issue_float_i  in  1  issued load targets FP RF
- issue_reg_id_i  in  reg_addr_width_p  destination register of issued load
- resp_v_i  in  1  response valid from RX
- resp_data_i  in  data_width_p  raw 32-bit response word
- resp_load_info_i  in  bsg_manycore_load_info_s  echoed load info
- resp_reg_id_i  in  reg_addr_width_p  echoed destination register
- resp_ready_o  out  1  FIFO can accept
- int_wb_v_o  out  1  integer writeback request
- int_wb_reg_o  out  reg_addr_width_p  integer destination register
- int_wb_data_o  out  data_width_p  extended load data
- int_wb_yumi_i  in  1  pipeline took integer writeback
- float_wb_v_o / float_wb_reg_o / float_wb_data_o / float_wb_yumi_i  as integer set, for the FP RF
- icache_v_o  out  1  icache fill word valid
- icache_data_o  out  data_width_p  raw instruction word
- icache_yumi_i  in  1  icache consumed fill
- out_credits_o  out  clog2(max_out_credits_p+1)  outstanding count
- credit_avail_o  out  1  out_credits_o != max_out_credits_p
- int_pending_o  out  32  pending-load bit per integer register
- float_pending_o  out  32  pending-load bit per FP register

Behaviour:
- Reset: FIFO empty; counter 0; both scoreboards 0; all *_v_o 0; resp_ready_o 1 on the first cycle after reset.
- Reset mid-operation drops every buffered response and pending bit with no writeback.
- Enqueue on resp_v_i & resp_ready_o. resp_ready_o = FIFO not full; it does not depend on same-cycle dequeue.
- Head routing is exclusive, by priority:
  - icache_fetch -> icache_v_o.
  - else float_wb -> float_wb_v_o.
  - else int_wb_v_o.
- Head pops (retires) on the matching yumi.
- An integer head with reg_id==0 retires internally one cycle after reaching head with int_wb_v_o=0.
- Latency: response accepted at cycle N appears at head at N+1, assuming an empty FIFO.
- Integer extraction, with ps=part_sel:
  - byte: byte ps of the data word; zero-extend if is_unsigned_op, else sign-extend from bit 7.
  - hex: halfword selected by ps[1]; ps[0] ignored; same extension rule.
  - word: raw data.
- FP and icache data pass through raw.
- Credit counter: +1 on issue_v_i, -1 on retire, unchanged when both occur in the same cycle.
  - Saturates at max_out_credits_p and at 0.
  - A simulation-only error fires on issue at max or retire at 0.
- Scoreboards:
  - Set bit issue_reg_id_i of the int/FP vector on issue_v_i & issue_load_i.
  - Integer x0 is never set.
  - Clear the bit of the retiring head's reg_id and class.
  - Set wins over clear for the same bit in the same cycle.
- Outputs hold stable while valid and not yumi'd.
- Simulation-only error if any yumi is asserted without its valid.

Optional Feature:
- Macro REMOTE_LOAD_WB_BYPASS_EN.
- Defined: when the FIFO is empty and resp_v_i is high, the response drives the routed output combinationally in the same cycle.
  - If the matching yumi (or x0 internal retire) occurs that cycle, the response is never enqueued and retires immediately.
  - Otherwise it enqueues normally.
  - Credit and scoreboard update on that retire.
- Undefined: minimum latency is 1 cycle through the FIFO.

Test Plan:
- Reset, then issue lb to x5 at cycle 0; response data 0x80FF7F01, part_sel=2, signed byte, yumi held -> int_wb_v_o at N+1, reg 5, data 0xFFFFFFFF; int_pending_o[5] 1->0; out_credits_o 1->0.
- lhu to x7, data 0x8001ABCD, part_sel=2 -> int_wb_data_o 0x00008001; lh same with part_sel=0 -> 0xFFFFABCD.
- flw to f3 and icache fill queued back-to-back, yumis held low 3 cycles -> FIFO fills, resp_ready_o=0; release -> icache_v_o first with raw data, then float_wb_v_o reg 3; credits return to 0.
- Load to x0 -> no int_wb_v_o; retires after one cycle at head; credit decrements; int_pending_o stays 0.
- Issue load to x9 in the same cycle an older x9 load retires -> int_pending_o[9] remains 1; credits unchanged that cycle.
- Issue max_out_credits_p requests with no responses -> credit_avail_o=0 at count 32; one retire -> 31, credit_avail_o=1; assert reset with 2 buffered responses -> no writebacks, all outputs zero.
